uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU data bus, downstream of the CPU's `addr`/`do`/`we` outputs.
- An `ST` to its data register queues a byte in a small FIFO; the block serialises queued bytes 8N1, LSB first, on `tx`.
- An `LD` from its status register returns busy/full/empty/overflow, so firmware can poll before writing.
- It sits beside program RAM; the top-level bus mux selects `rdata` when `sel` is high.

Parameters:
- BASE_ADDR, 16'hFF00, first of 4 consecutive byte addresses owned by the block.
- CLKS_PER_BIT, 434, clk cycles per serial bit; legal range ≥ 2.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of two, ≥ 2.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  16  CPU bus address.
- wdata  input  8  CPU write data (the CPU's `do`).
- we  input  1  CPU write strobe; a one-cycle pulse per store.
- rdata  output  8  registered read data.
- sel  output  1  combinational; 1 when addr is in BASE_ADDR..BASE_ADDR+3.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, rdata=0, FIFO empty (pointers and count 0), overflow=0, FSM=IDLE, baud counter=0, bit index=0.
- Register map (offset from BASE_ADDR):
  - +0 DATA: write pushes wdata into the FIFO; reads return 0.
  - +1 STATUS: read only. bit0=busy (FSM≠IDLE), bit1=fifo_full, bit2=fifo_empty, bit3=overflow; bits7:4 read 0.
  - +2 CLEAR: any write clears overflow; reads return 0.
  - +3: reserved; writes ignored, reads return 0.
- Read timing:
  - rdata is updated every edge: the addressed register value when sel=1, else 0.
  - One-cycle latency, which fits the CPU sampling `di` two cycles after it drives a data address.
- Write decode:
  - A write takes effect on the edge where we=1 and sel=1.
  - we with sel=0 is ignored.
- FIFO:
  - Circular buffer; read/write pointers of log2(FIFO_DEPTH) bits wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
  - Push while full (count==FIFO_DEPTH): the byte is dropped, contents are unchanged, and overflow is set (sticky).
  - The full check uses the pre-edge count. A push is dropped even if a pop happens on the same edge.
  - A push and a pop on the same edge when not full leave count unchanged.
- Transmit FSM: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO not empty: pop the head into the shift register, load baud counter = CLKS_PER_BIT-1, tx<=0, go to START.
  - START: when baud counter==0, tx<=shift[0], reload the counter, set bit index=0, go to DATA; otherwise decrement.
  - DATA: when baud counter==0:
    - if bit index==7: tx<=1, reload, go to STOP;
    - else: shift right, tx<=next bit, increment bit index, reload.
  - STOP: when baud counter==0:
    - if FIFO not empty: pop, tx<=0, reload, go to START (back-to-back frames, no idle cycle);
    - else go to IDLE.
- Latency and frame timing:
  - A write on edge N makes the FIFO non-empty after N. Edge N+1 pops the byte and drives tx low.
  - Each bit lasts exactly CLKS_PER_BIT cycles; a frame is 10×CLKS_PER_BIT cycles.
- Status view: busy=1 from the IDLE→START edge until the STOP→IDLE edge. A byte being shifted does not count toward fifo_full.
- Simultaneous write to CLEAR and an overflowing push: the clear wins only if the two are on different edges. The bus allows one write per cycle, so the case cannot occur.

Decomposition:
- Shared constants file (alongside the existing ISA constants): UART_BASE_ADDR; register offsets UART_DATA=0, UART_STATUS=1, UART_CLEAR=2; STATUS bit positions.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, with async active-high reset).
  - The FIFO drops pushes when full; overflow is flagged in the parent.
- Baud counter and FSM stay in uart_tx_mmio.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=16'hFF00):
- Reset, then idle 20 cycles → tx=1 throughout; read 0xFF01 → rdata=8'h04 one cycle later.
- Write 8'hA5 to 0xFF00 → tx low one edge after the write edge, for 4 cycles; then bits 1,0,1,0,0,1,0,1, 4 cycles each; then stop=1; busy=1 for exactly 40 cycles.
- Write 8'h01, 8'h02, 8'h03 on consecutive write pulses → three frames back-to-back, stop bit of frame k followed immediately by start bit of frame k+1; total 120 cycles busy.
- Write 6 bytes rapidly (first pops immediately, next 4 fill the FIFO, 6th dropped) → STATUS reads 8'h0B (busy, full, overflow); write to 0xFF02 → STATUS bit3=0; only 5 frames transmitted.
- Assert rst mid-DATA of a frame → tx=1 without waiting for clk; after release STATUS=8'h04, no residual frame.
- Write to 0xFE00 and 0xFF03 → sel=0 / no FIFO push respectively, tx stays 1; read 0xFE00 → rdata=0.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_mmio_pkg : address map, register offsets and FSM encoding for the
//                    memory-mapped UART transmitter.
// Revision: 1.0
// ============================================================================
package uart_tx_mmio_pkg;

    localparam logic [15:0] UART_BASE_ADDR = 16'hFF00;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CLEAR  = 2'd2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_mmio_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : circular-buffer FIFO; pushes while full and pops while empty
//             are ignored. Head entry is presented combinationally on dout.
// Revision: 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap without explicit compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// uart_tx_mmio : memory-mapped 8N1 UART transmitter with a TX FIFO, status
//                register, sticky overflow flag and registered read data.
// Revision: 1.0
// ============================================================================
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = UART_BASE_ADDR,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        sel,
    output logic        tx
);

    localparam int            CW          = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [15:0]   offset;
    logic [1:0]    reg_off;
    logic          wr_en;
    logic          push;
    logic          pop;
    logic          clr;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow;
    logic [7:0]    status;
    tx_state_t     state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Subtracting the base keeps the window test correct for unaligned bases.
    assign offset  = addr - BASE_ADDR;
    assign sel     = (offset[15:2] == 14'd0);
    assign reg_off = offset[1:0];
    assign wr_en   = we && sel;
    assign push    = wr_en && (reg_off == UART_DATA);
    assign clr     = wr_en && (reg_off == UART_CLEAR);
    assign pop     = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && (baud == '0)));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wdata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status             = '0;
        status[STAT_BUSY]  = (state != ST_IDLE);
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_OVF]   = overflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && fifo_full) begin
            overflow <= 1'b1;
        end else if (clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (sel && (reg_off == UART_STATUS)) begin
            rdata <= status;
        end else begin
            rdata <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift <= fifo_dout;
                        baud  <= BAUD_RELOAD;
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud == '0) begin
                        tx      <= shift[0];
                        baud    <= BAUD_RELOAD;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud == '0) begin
                        baud <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud == '0) begin
                        // Chain straight into the next start bit when data waits.
                        if (!fifo_empty) begin
                            shift <= fifo_dout;
                            baud  <= BAUD_RELOAD;
                            tx    <= 1'b0;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_mmio : directed bench; written bytes go to a scoreboard queue and
//                   a line monitor checks every tx cycle of each frame.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_mmio;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic        sel;
    logic        tx;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [7:0]  sb [$];
    int          frame_starts [$];
    bit          in_frame = 1'b0;
    bit          bogus    = 1'b0;
    int          t        = 0;
    logic [7:0]  cur      = '0;
    int          busy_cnt;

    uart_tx_mmio #(
        .BASE_ADDR    (16'hFF00),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .sel   (sel),
        .tx    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line monitor: every cycle of a frame is compared against the queued byte.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else if (in_frame || tx === 1'b0) begin
            int k;
            logic exp_bit;
            if (!in_frame) begin
                in_frame = 1'b1;
                t = 0;
                frame_starts.push_back(cyc);
                if (sb.size() == 0) begin
                    bogus = 1'b1;
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    bogus = 1'b0;
                    cur = sb[0];
                end
            end
            if (!bogus) begin
                k = t / CPB;
                exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : cur[k-1];
                check($sformatf("frame_%02h_bit%0d", cur, k), {31'd0, tx}, {31'd0, exp_bit});
            end
            t++;
            if (t == 10 * CPB) begin
                in_frame = 1'b0;
                if (!bogus) void'(sb.pop_front());
            end
        end
    end

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d, input bit sent);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        if (sent) sb.push_back(d);
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic read_reg(input logic [15:0] a, input logic [7:0] exp, input string tag);
        addr = a;
        we   = 1'b0;
        @(posedge clk);
        #1;
        check(tag, {24'd0, rdata}, {24'd0, exp});
    endtask

    task automatic wait_drain(input int max_cycles, input string tag);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0 && !in_frame) break;
            @(posedge clk);
            #1;
        end
        check(tag, {31'd0, (i == max_cycles)}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        addr  = 16'h0000;
        wdata = 8'h00;
        we    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_rdata", {24'd0, rdata}, 32'd0);
        check("reset_sel", {31'd0, sel}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx", {31'd0, tx}, 32'd1);
        end
        @(posedge clk);
        #1;
        read_reg(16'hFF01, 8'h04, "status_after_reset");

        // Single frame: start bit one edge after the write, 40 busy cycles.
        write_reg(16'hFF00, 8'hA5, 1'b1);
        check("tx_before_start", {31'd0, tx}, 32'd1);
        addr = 16'hFF01;
        @(posedge clk);
        #1;
        check("tx_start_latency", {31'd0, tx}, 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (rdata[0]) busy_cnt++;
        end
        check("busy_cycles_a5", busy_cnt, 32'd40);
        wait_drain(100, "drain_a5");

        // Three queued bytes leave back-to-back.
        frame_starts.delete();
        write_reg(16'hFF00, 8'h01, 1'b1);
        write_reg(16'hFF00, 8'h02, 1'b1);
        write_reg(16'hFF00, 8'h03, 1'b1);
        addr = 16'hFF01;
        busy_cnt = 0;
        for (int i = 0; i < 140; i++) begin
            @(posedge clk);
            #1;
            if (rdata[0]) busy_cnt++;
        end
        // The third write's edge reads DATA, so one of the 120 busy cycles is unseen.
        check("busy_cycles_3", busy_cnt, 32'd119);
        wait_drain(100, "drain_3");
        check("frames_3", frame_starts.size(), 32'd3);
        if (frame_starts.size() == 3) begin
            check("gap_1_2", frame_starts[1] - frame_starts[0], 32'd40);
            check("gap_2_3", frame_starts[2] - frame_starts[1], 32'd40);
        end

        // Overflow: sixth byte dropped, flag sticky until CLEAR.
        frame_starts.delete();
        write_reg(16'hFF00, 8'h10, 1'b1);
        write_reg(16'hFF00, 8'h11, 1'b1);
        write_reg(16'hFF00, 8'h12, 1'b1);
        write_reg(16'hFF00, 8'h13, 1'b1);
        write_reg(16'hFF00, 8'h14, 1'b1);
        write_reg(16'hFF00, 8'h15, 1'b0);
        read_reg(16'hFF01, 8'h0B, "status_overflow");
        read_reg(16'hFF01, 8'h0B, "status_overflow_sticky");
        write_reg(16'hFF02, 8'h00, 1'b0);
        read_reg(16'hFF01, 8'h03, "status_after_clear");
        wait_drain(400, "drain_ovf");
        check("frames_ovf", frame_starts.size(), 32'd5);
        read_reg(16'hFF01, 8'h04, "status_after_ovf_drain");

        // Asynchronous reset in the middle of the data bits.
        write_reg(16'hFF00, 8'h5A, 1'b1);
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("tx_async_reset", {31'd0, tx}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame_starts.delete();
        read_reg(16'hFF01, 8'h04, "status_after_midframe_reset");
        repeat (60) @(posedge clk);
        #1;
        check("no_residual_frame", frame_starts.size(), 32'd0);
        check("tx_idle_after_reset", {31'd0, tx}, 32'd1);

        // Address decode edges and ignored writes.
        addr = 16'hFE00;
        #1;
        check("sel_fe00", {31'd0, sel}, 32'd0);
        addr = 16'hFEFF;
        #1;
        check("sel_feff", {31'd0, sel}, 32'd0);
        addr = 16'hFF03;
        #1;
        check("sel_ff03", {31'd0, sel}, 32'd1);
        addr = 16'hFF04;
        #1;
        check("sel_ff04", {31'd0, sel}, 32'd0);
        write_reg(16'hFE00, 8'h55, 1'b0);
        write_reg(16'hFF03, 8'h66, 1'b0);
        repeat (60) @(posedge clk);
        #1;
        check("no_frame_unmapped", frame_starts.size(), 32'd0);
        check("tx_idle_unmapped", {31'd0, tx}, 32'd1);
        read_reg(16'hFE00, 8'h00, "read_unmapped");
        read_reg(16'hFF00, 8'h00, "read_data_reg");
        read_reg(16'hFF01, 8'h04, "status_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
